// File: rtl/phy_tx_lane_serializer.sv
// Four-lane byte-striping transmit serializer: one frame = lane0..lane3 bytes, MSB first.
// A 5-bit counter provides the frame/byte timing; an FSM chooses COM training or lane data.
module phy_tx_lane_serializer #(
  parameter logic [7:0]  COM_BYTE  = 8'hBC,
  parameter logic [7:0]  IDLE_BYTE = 8'h7C,
  parameter int unsigned MIN_COM   = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  input  logic       rx_active,
  output logic       data_out,
  output logic       frame_strb,
  output logic       tx_active
);

  typedef enum logic {TRAIN, ACTIVE} state_t;

  localparam logic [8:0] MIN_COM_W = 9'(MIN_COM);

  logic [4:0] cnt;
  logic [7:0] shift;
  state_t     state;
  state_t     next_state;
  logic [7:0] com_cnt;
  logic [7:0] hold1, hold2, hold3;
  logic       hold_v1, hold_v2, hold_v3;
  logic       frame_end;
  logic       byte_end;
  logic [8:0] com_sent;
  logic [7:0] next_byte;

  assign frame_end  = (cnt == 5'd31);
  assign byte_end   = (cnt[2:0] == 3'd7);
  assign frame_strb = frame_end;
  assign data_out   = shift[7];
  assign tx_active  = (state == ACTIVE);

  // The COM byte finishing on the boundary edge already counts as sent.
  assign com_sent = {1'b0, com_cnt} + 9'd1;

  always_comb begin
    next_state = state;
    if (frame_end) begin
      case (state)
        TRAIN:   if (rx_active && (com_sent >= MIN_COM_W)) next_state = ACTIVE;
        ACTIVE:  if (!rx_active) next_state = TRAIN;
        default: next_state = TRAIN;
      endcase
    end
  end

  // Lane0 comes from the live inputs under next_state; lanes 1-3 from the hold registers.
  always_comb begin
    next_byte = COM_BYTE;
    if (frame_end) begin
      if (next_state == ACTIVE) next_byte = valid0 ? in0 : IDLE_BYTE;
    end else if (state == ACTIVE) begin
      case (cnt[4:3])
        2'd0:    next_byte = hold_v1 ? hold1 : IDLE_BYTE;
        2'd1:    next_byte = hold_v2 ? hold2 : IDLE_BYTE;
        default: next_byte = hold_v3 ? hold3 : IDLE_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      cnt     <= 5'd0;
      shift   <= COM_BYTE;
      state   <= TRAIN;
      com_cnt <= 8'd0;
      hold1   <= 8'd0;
      hold2   <= 8'd0;
      hold3   <= 8'd0;
      hold_v1 <= 1'b0;
      hold_v2 <= 1'b0;
      hold_v3 <= 1'b0;
    end else begin
      cnt   <= cnt + 5'd1;
      state <= next_state;
      if (byte_end) shift <= next_byte;
      else          shift <= {shift[6:0], 1'b0};
      if (frame_end) begin
        hold1   <= in1;
        hold2   <= in2;
        hold3   <= in3;
        hold_v1 <= valid1;
        hold_v2 <= valid2;
        hold_v3 <= valid3;
      end
      if (frame_end && (state == ACTIVE) && !rx_active)
        com_cnt <= 8'd0;
      else if ((state == TRAIN) && byte_end && (com_cnt != 8'd255))
        com_cnt <= com_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Self-checking bench: a frame-level model predicts every output bit, plus literal frame checks.
module tb_phy_tx_lane_serializer;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int         MINC = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] in0 = 8'h00, in1 = 8'h00, in2 = 8'h00, in3 = 8'h00;
  logic       valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0, valid3 = 1'b0;
  logic       rx_active = 1'b0;
  logic       data_out, frame_strb, tx_active;

  int errors = 0;
  int checks = 0;

  // Model state: position of the current cycle in its frame, link state, COM bytes sent, frame bits.
  int          mPos    = 0;
  bit          mActive = 1'b0;
  int          mComs   = 0;
  logic [31:0] mFrame  = {COM, COM, COM, COM};

  phy_tx_lane_serializer #(.COM_BYTE(COM), .IDLE_BYTE(IDLE), .MIN_COM(MINC)) dut (
    .clk_32f(clk_32f), .reset(reset),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .rx_active(rx_active),
    .data_out(data_out), .frame_strb(frame_strb), .tx_active(tx_active)
  );

  always #5 clk_32f = ~clk_32f;

  function automatic logic [7:0] laneByte(input bit act, input logic [7:0] d, input logic v);
    if (!act) return COM;
    return v ? d : IDLE;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Inputs change 2 time units after a rising edge, well clear of both clock edges.
  task automatic applyStimulus(input logic [7:0] d0, d1, d2, d3, input logic [3:0] v, input logic rx);
    @(posedge clk_32f); #2;
    in0 = d0; in1 = d1; in2 = d2; in3 = d3;
    {valid3, valid2, valid1, valid0} = v;
    rx_active = rx;
  endtask

  task automatic waitPos(input int p);
    int n = 0;
    do begin
      @(posedge clk_32f); #2;
      n++;
    end while (mPos != p && n < 64);
    if (mPos != p) checkOutput("waitPos timeout", 32'(mPos), 32'(p));
  endtask

  task automatic collectFrame(input bit waitStart, input int changeAt, input logic [7:0] newIn2,
                              output logic [31:0] bits);
    if (waitStart) waitPos(0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_32f);
      bits[31-i] = data_out;
      if (i == changeAt) in2 = newIn2;
    end
  endtask

  // Per-cycle compare against the model, then advance the model over the coming rising edge.
  initial begin
    forever begin
      @(negedge clk_32f);
      if (reset) begin
        mPos = 0; mActive = 1'b0; mComs = 0; mFrame = {COM, COM, COM, COM};
        checks += 3;
        if (data_out !== 1'b1 || frame_strb !== 1'b0 || tx_active !== 1'b0) begin
          errors++;
          $display("[TB] FAIL reset outputs: got do=%b fs=%b ta=%b, expected 1 0 0",
                   data_out, frame_strb, tx_active);
        end
      end else begin
        checks += 3;
        if (data_out !== mFrame[31-mPos] || frame_strb !== (mPos == 31) || tx_active !== mActive) begin
          errors++;
          $display("[TB] FAIL cycle pos=%0d: got do=%b fs=%b ta=%b, expected %b %b %b", mPos,
                   data_out, frame_strb, tx_active, mFrame[31-mPos], (mPos == 31), mActive);
        end
        if (!mActive && (mPos % 8) == 7 && mComs != 255) mComs++;
        if (mPos == 31) begin
          if (mActive && !rx_active) begin
            mActive = 1'b0;
            mComs   = 0;
          end else if (!mActive && rx_active && mComs >= MINC) begin
            mActive = 1'b1;
          end
          mFrame = {laneByte(mActive, in0, valid0), laneByte(mActive, in1, valid1),
                    laneByte(mActive, in2, valid2), laneByte(mActive, in3, valid3)};
        end
        mPos = (mPos + 1) % 32;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] f;
    int strbCount;

    // Training only: COM stream, one strobe per 32 cycles, never active.
    repeat (3) @(posedge clk_32f);
    #2 reset = 1'b0;
    strbCount = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_32f);
      if (frame_strb) strbCount++;
    end
    checkOutput("strobe count 256 cycles", 32'(strbCount), 32'd8);
    checkOutput("tx_active while training", {31'd0, tx_active}, 32'd0);
    collectFrame(1'b1, -1, 8'h00, f);
    checkOutput("training frame", f, 32'hBCBCBCBC);

    // Sync from release: one COM frame, then data.
    @(posedge clk_32f); #2 reset = 1'b1;
    in0 = 8'hA5; in1 = 8'h3C; in2 = 8'hF0; in3 = 8'h0F;
    {valid3, valid2, valid1, valid0} = 4'hF;
    rx_active = 1'b1;
    repeat (2) @(posedge clk_32f);
    #2 reset = 1'b0;
    collectFrame(1'b0, -1, 8'h00, f);
    checkOutput("frame0 COM", f, 32'hBCBCBCBC);
    collectFrame(1'b1, -1, 8'h00, f);
    checkOutput("frame1 data", f, 32'hA53CF00F);
    checkOutput("tx_active after sync", {31'd0, tx_active}, 32'd1);

    // Invalid lane1 becomes IDLE.
    applyStimulus(8'hA5, 8'h3C, 8'hF0, 8'h0F, 4'b1101, 1'b1);
    collectFrame(1'b1, -1, 8'h00, f);
    checkOutput("lane1 idle", f, 32'hA57CF00F);

    // Sync loss mid-frame, then recovery after exactly one COM frame.
    applyStimulus(8'hA5, 8'h3C, 8'hF0, 8'h0F, 4'hF, 1'b1);
    waitPos(10);
    rx_active = 1'b0;
    waitPos(0);
    rx_active = 1'b1;
    collectFrame(1'b0, -1, 8'h00, f);
    checkOutput("COM frame after sync loss", f, 32'hBCBCBCBC);
    collectFrame(1'b1, -1, 8'h00, f);
    checkOutput("data resumes", f, 32'hA53CF00F);

    // Reset mid-frame while active.
    waitPos(13);
    reset = 1'b1;
    @(negedge clk_32f);
    checkOutput("data_out in reset", {31'd0, data_out}, 32'd1);
    checkOutput("tx_active in reset", {31'd0, tx_active}, 32'd0);
    repeat (3) @(posedge clk_32f);
    #2 reset = 1'b0;
    collectFrame(1'b0, -1, 8'h00, f);
    checkOutput("COM frame after reset", f, 32'hBCBCBCBC);
    collectFrame(1'b1, -1, 8'h00, f);
    checkOutput("data after reset", f, 32'hA53CF00F);

    // Mid-frame input change is deferred to the next frame.
    waitPos(0);
    collectFrame(1'b0, 5, 8'h55, f);
    checkOutput("frame before in2 change", f, 32'hA53CF00F);
    collectFrame(1'b1, -1, 8'h00, f);
    checkOutput("frame after in2 change", f, 32'hA53C550F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
